// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by the ALU core and its bench.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_NOT, OP_SUB, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_XNOR,
    OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_INC, OP_DEC
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_DIV0  = 2;
  localparam int FLAG_ERR   = 3;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiply / restoring divide sharing a {hi,lo} register pair.
module alu_muldiv_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] result
);
  localparam int CW = $clog2(W);
  logic [W-1:0] hi, lo, bb, hi_n, lo_n;
  logic [W:0] sum, r, trial;
  logic [CW-1:0] cnt;
  logic op_q, busy;
  // mul: {hi,lo} is the product shifting right; div: hi is remainder, lo shifts dividend out and quotient in
  always_comb begin
    sum = {1'b0, hi} + {1'b0, bb & {W{lo[0]}}};
    r = {hi, lo[W-1]};
    trial = r - {1'b0, bb};
    hi_n = op_q ? (trial[W] ? r[W-1:0] : trial[W-1:0]) : sum[W:1];
    lo_n = op_q ? {lo[W-2:0], ~trial[W]} : {sum[0], lo[W-1:1]};
  end
  assign result = {hi_n, lo_n};
  assign done = busy && cnt == CW'(W - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      bb <= '0;
      op_q <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      hi <= '0;
      lo <= a;
      bb <= b;
      op_q <= op;
      busy <= 1'b1;
      cnt <= '0;
    end else if (busy) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: valid/ready sequenced ALU; single-cycle ops go straight to DONE, iterative MUL/DIV pass through EXEC.
module alu_seq_core import alu_pkg::*; #(
  parameter int W = 8,
  parameter int MD_ITER = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cin,
  input  logic [3:0]     f,
  output logic [2*W-1:0] d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3:0]     flags
);
  state_e state, state_n;
  logic accept, go_exec, md_done, err, div0, carry;
  logic [2*W-1:0] md_res, c_d;
  logic [W:0] ar;
  logic [3:0] c_flags;
  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign accept = in_valid && in_ready;
  // divide by zero never enters EXEC: its fixed answer is ready immediately
  assign go_exec = MD_ITER != 0 && (f == OP_MUL || (f == OP_DIV && b != '0));
  always_comb begin
    ar = '0;
    c_d = '0;
    err = 1'b0;
    div0 = 1'b0;
    carry = 1'b0;
    case (f)
      OP_NOT:  c_d = {{W{1'b0}}, ~a};
      OP_SUB:  begin ar = {1'b0, a} - {1'b0, b} - (W+1)'(cin); c_d = {{W{1'b0}}, ar[W-1:0]}; carry = ar[W]; end
      OP_ADD:  begin ar = {1'b0, a} + {1'b0, b} + (W+1)'(cin); c_d = {{(W-1){1'b0}}, ar}; carry = ar[W]; end
      OP_AND:  c_d = {{W{1'b0}}, a & b};
      OP_OR:   c_d = {{W{1'b0}}, a | b};
      OP_XOR:  c_d = {{W{1'b0}}, a ^ b};
      OP_XNOR: c_d = {{W{1'b0}}, ~(a ^ b)};
      OP_MUL:  c_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      OP_DIV:  begin div0 = b == '0; c_d = div0 ? {a, {W{1'b1}}} : {a % b, a / b}; end
      OP_SHL:  begin ar = {a, 1'b0}; c_d = {{(W-1){1'b0}}, ar}; carry = ar[W]; end
      OP_SHR:  c_d = {{W{1'b0}}, a >> 1};
      OP_INC:  begin ar = {1'b0, a} + (W+1)'(1); c_d = {{(W-1){1'b0}}, ar}; carry = ar[W]; end
      OP_DEC:  begin ar = {1'b0, a} - (W+1)'(1); c_d = {{W{1'b0}}, ar[W-1:0]}; carry = ar[W]; end
      default: err = 1'b1;
    endcase
    c_flags = '0;
    c_flags[FLAG_ERR] = err;
    c_flags[FLAG_DIV0] = div0;
    c_flags[FLAG_CARRY] = carry;
    c_flags[FLAG_ZERO] = c_d == '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = accept ? (go_exec ? S_EXEC : S_DONE) : S_IDLE;
      S_EXEC:  state_n = md_done ? S_DONE : S_EXEC;
      S_DONE:  state_n = out_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      d <= '0;
      flags <= '0;
    end else begin
      state <= state_n;
      if (accept && !go_exec) begin
        d <= c_d;
        flags <= c_flags;
      end else if (state == S_EXEC && md_done) begin
        d <= md_res;
        flags <= {3'b000, md_res == '0};
      end
    end
  if (MD_ITER != 0) begin : g_iter
    alu_muldiv_iter #(.W(W)) u_md (
      .clk(clk), .rst_n(rst_n), .start(accept && go_exec), .op(f == OP_DIV),
      .a(a), .b(b), .done(md_done), .result(md_res)
    );
  end else begin : g_comb
    assign md_done = 1'b0;
    assign md_res = '0;
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed vectors with hand-computed results for the W=8 iterative ALU core.
module tb_alu_seq_core;
  import alu_pkg::*;
  logic clk = 0, rst_n = 1, in_valid = 0, cin = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] a = 0, b = 0;
  logic [3:0] f = 0, flags;
  logic [15:0] d;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_seq_core #(.W(8), .MD_ITER(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .f(f), .d(d), .out_valid(out_valid), .out_ready(out_ready), .flags(flags)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, input logic c);
    chk("ready before send", 32'(in_ready), 1);
    in_valid = 1; f = op; a = x; b = y; cin = c;
    @(posedge clk); #1;
    in_valid = 0; f = ~op; a = ~x; b = ~y; cin = ~c;
  endtask
  task automatic await(output int n, output logic rdy);
    n = 1; rdy = 0;
    while (!out_valid && n < 40) begin
      rdy |= in_ready;
      @(posedge clk); #1;
      n++;
    end
    rdy |= in_ready;
  endtask
  task automatic take;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("ready after take", 32'(in_ready), 1);
    chk("valid after take", 32'(out_valid), 0);
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                     input logic c, input int lat, input logic [15:0] ed, input logic [3:0] ef);
    int n;
    logic rdy;
    send(op, x, y, c);
    await(n, rdy);
    chk({tag, " latency"}, n, lat);
    chk({tag, " ready while busy"}, 32'(rdy), 0);
    chk({tag, " d"}, 32'(d), 32'(ed));
    chk({tag, " flags"}, 32'(flags), 32'(ef));
    take;
  endtask
  initial begin
    logic hold_ok, seen;
    #1 rst_n = 0;
    #11;
    chk("reset d", 32'(d), 0);
    chk("reset flags", 32'(flags), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready after reset", 32'(in_ready), 1);
    run("add", OP_ADD, 8'hFF, 8'h01, 1, 1, 16'h0101, 4'b0010);
    run("mul", OP_MUL, 8'hFF, 8'hFF, 0, 9, 16'hFE01, 4'b0000);
    run("div", OP_DIV, 8'd200, 8'd7, 0, 9, 16'h041C, 4'b0000);
    run("div0", OP_DIV, 8'd200, 8'd0, 0, 1, 16'hC8FF, 4'b0100);
    run("op14", 4'd14, 8'h5A, 8'h33, 1, 1, 16'h0000, 4'b1001);
    run("dec0", OP_DEC, 8'h00, 8'h55, 1, 1, 16'h00FF, 4'b0010);
    run("inc", OP_INC, 8'hFF, 8'h00, 1, 1, 16'h0100, 4'b0010);
    run("shl", OP_SHL, 8'h81, 8'h00, 0, 1, 16'h0102, 4'b0010);
    run("not", OP_NOT, 8'hFF, 8'h00, 0, 1, 16'h0000, 4'b0001);
    run("xnor", OP_XNOR, 8'hA5, 8'h0F, 0, 1, 16'h0055, 4'b0000);
    run("sub", OP_SUB, 8'd10, 8'd3, 1, 1, 16'h0006, 4'b0000);
    send(OP_SUB, 8'd3, 8'd5, 0);
    chk("bp valid", 32'(out_valid), 1);
    chk("bp d", 32'(d), 32'h00FE);
    chk("bp flags", 32'(flags), 32'b0010);
    hold_ok = 1;
    repeat (5) begin
      @(posedge clk); #1;
      hold_ok &= d === 16'h00FE && flags === 4'b0010 && out_valid === 1'b1 && in_ready === 1'b0;
    end
    chk("bp hold", 32'(hold_ok), 1);
    take;
    send(OP_MUL, 8'h0D, 8'h0B, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid mul busy", 32'(in_ready), 0);
    rst_n = 0;
    #1;
    chk("mid rst d", 32'(d), 0);
    chk("mid rst flags", 32'(flags), 0);
    chk("mid rst valid", 32'(out_valid), 0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk("ready after mid rst", 32'(in_ready), 1);
    seen = 0;
    repeat (12) begin
      seen |= out_valid;
      @(posedge clk); #1;
    end
    chk("no result after rst", 32'(seen), 0);
    run("mul2", OP_MUL, 8'h0D, 8'h0B, 0, 9, 16'h008F, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits (legal 4..32).
REQ-002 SHALL have parameter MD_ITER, default 1: 1 = iterative multiply/divide, 0 = single-cycle multiply/divide.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operation request.
REQ-006 SHALL have port in_ready, output, 1, core can accept an operation.
REQ-007 SHALL have port a, input, W, operand A.
REQ-008 SHALL have port b, input, W, operand B.
REQ-009 SHALL have port cin, input, 1, carry/borrow-in for add and subtract.
REQ-010 SHALL have port f, input, 4, opcode.
REQ-011 SHALL have port d, output, 2W, result.
REQ-012 SHALL have port out_valid, output, 1, result and flags valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-014 SHALL have port flags, output, 4: {err, div0, carry, zero}.

Function
REQ-015 SHALL use opcodes 0 NOT, 1 SUB, 2 ADD, 3 AND, 4 OR, 5 XOR, 6 XNOR, 7 MUL, 8 DIV, 9 SHL, 10 SHR, 11 INC, 12 DEC; NOT/AND/OR/XNOR are bitwise on W bits.
REQ-016 SHALL capture a, b, cin and f on the cycle in_valid and in_ready are both high; later input changes have no effect.
REQ-017 SHALL run the FSM IDLE -> EXEC (MUL/DIV with MD_ITER=1 only) -> DONE -> IDLE; other opcodes go IDLE -> DONE.
REQ-018 SHALL drive in_ready high only in IDLE.
REQ-019 SHALL assert out_valid exactly in DONE; single-cycle ops give out_valid the cycle after acceptance.
REQ-020 SHALL hold d and flags stable while out_valid is high and out_ready is low.
REQ-021 SHALL leave DONE for IDLE on the cycle out_ready is high.
REQ-022 SHALL zero-extend ADD/SUB/INC/DEC/SHL results to 2W; carry = bit W of the (W+1)-bit result (for SUB/DEC: 1 = borrow).
REQ-023 SHALL compute SUB as a - b - cin and ADD as a + b + cin; INC/DEC ignore cin.
REQ-024 SHALL produce the full 2W-bit unsigned product for MUL.
REQ-025 SHALL produce DIV as unsigned quotient in d[W-1:0] and remainder in d[2W-1:W].
REQ-026 SHALL, with MD_ITER=1, spend exactly W cycles in EXEC (shift-add / restoring divide, one bit per cycle), giving out_valid W+1 cycles after acceptance.
REQ-027 SHALL, on b = 0 for DIV, skip EXEC and return quotient all-ones, remainder = a, div0 = 1.
REQ-028 SHALL, for opcodes 13..15, return d = 0 and err = 1, with no other effect.
REQ-029 SHALL set zero = 1 when all 2W bits of d are 0; carry = 0 for non-arithmetic ops; div0 = 0 except per REQ-027.

Reset
REQ-030 SHALL, on rst_n low, force state IDLE, d = 0, flags = 0, out_valid = 0 and the iteration counter to 0 immediately, regardless of clk.
REQ-031 SHALL discard an in-flight EXEC operation on reset, with no result delivered.
REQ-032 SHALL drive in_ready high the first clock after rst_n deasserts.

Structure
REQ-033 SHALL take the opcode enum, flag bit indices and FSM state type from the shared package alu_pkg.
REQ-034 SHALL implement iterative multiply/divide in the sub-module alu_muldiv_iter (start, op, a, b -> done, result), instantiated only when MD_ITER=1.

Verification (W=8, MD_ITER=1)
REQ-035 SHALL check ADD: a=0xFF, b=0x01, cin=1 -> d=0x0101, carry=1, out_valid 1 cycle after accept.
REQ-036 SHALL check MUL: a=0xFF, b=0xFF -> d=0xFE01, out_valid exactly 9 cycles after accept, in_ready low throughout.
REQ-037 SHALL check DIV: a=200, b=7 -> d[7:0]=28, d[15:8]=4; then b=0 -> d[7:0]=0xFF, d[15:8]=a, div0=1, 1-cycle latency.
REQ-038 SHALL check backpressure: out_ready low 5 cycles on a SUB 3-5-0 -> d=0x00FE, carry=1, held stable, in_ready low until accept.
REQ-039 SHALL check reset mid-MUL (cycle 4 of EXEC): outputs zero immediately, no out_valid afterwards, in_ready high next cycle.
REQ-040 SHALL check opcode 14 -> d=0, err=1, zero=1.
